// File: rtl/ga_pkg.sv
// Shared types and helpers for the GA fitness scheduling slice.
package ga_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

  // Fitness polynomial f(x) = x^3 - FF_COEF_SQ*x^2 + FF_COEF_LIN*x
  localparam int FF_COEF_SQ  = 15;
  localparam int FF_COEF_LIN = 50;

  function automatic int fitness_width(input int chrom_w);
    return (chrom_w + 1) * 3;
  endfunction

  // Most-negative fitness value, sign-extended to 64 bits; slice to width at use.
  function automatic logic [63:0] fitness_min64(input int fw);
    return ~((64'd1 << (fw - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/fitness_function.sv
// Two-lane cubic fitness evaluator with a fixed LATENCY-cycle result pipeline.
module fitness_function
  import ga_pkg::*;
#(
  parameter  int CHROM_WIDTH = 8,
  parameter  int LATENCY     = 2,
  localparam int FW          = fitness_width(CHROM_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [CHROM_WIDTH-1:0] chrom1,
  input  logic signed [CHROM_WIDTH-1:0] chrom2,
  output logic signed [FW-1:0]          fitness1,
  output logic signed [FW-1:0]          fitness2
);

  logic signed [FW-1:0] r_f1 [LATENCY];
  logic signed [FW-1:0] r_f2 [LATENCY];

  // The width leaves headroom above 3*CHROM_WIDTH, so no term can overflow.
  function automatic logic signed [FW-1:0] poly(input logic signed [CHROM_WIDTH-1:0] x);
    logic signed [FW-1:0] xe;
    logic signed [FW-1:0] x2;
    xe = FW'(x);
    x2 = xe * xe;
    return (x2 * xe) - (FW'(FF_COEF_SQ) * x2) + (FW'(FF_COEF_LIN) * xe);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_f1[i] <= '0;
        r_f2[i] <= '0;
      end
    end else begin
      if (enable) begin
        r_f1[0] <= poly(chrom1);
        r_f2[0] <= poly(chrom2);
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_f1[i] <= r_f1[i-1];
        r_f2[i] <= r_f2[i-1];
      end
    end
  end

  assign fitness1 = r_f1[LATENCY-1];
  assign fitness2 = r_f2[LATENCY-1];

endmodule

// File: rtl/fitness_scheduler.sv
// Streams population pairs through one fitness_function, writes results back
// pairwise and tracks the best fitness/index of the run.
//
//   state | meaning
//   IDLE  | waiting for start; best values held
//   ISSUE | one pair read per cycle from the population RAM
//   DRAIN | waiting for the last pair to leave the fitness pipeline
//   DONE  | one-cycle completion pulse
module fitness_scheduler
  import ga_pkg::*;
#(
  parameter  int CHROM_WIDTH = 8,
  parameter  int POP_SIZE    = 16,
  parameter  int FF_LATENCY  = 2,
  localparam int ADDR_W      = $clog2(POP_SIZE),
  localparam int FW          = fitness_width(CHROM_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [CHROM_WIDTH-1:0] chrom_rdata1,
  input  logic [CHROM_WIDTH-1:0] chrom_rdata2,
  output logic                   fit_wr_en,
  output logic [ADDR_W-1:0]      fit_wr_addr,
  output logic [FW-1:0]          fit_wdata1,
  output logic [FW-1:0]          fit_wdata2,
  output logic [FW-1:0]          best_fitness,
  output logic [ADDR_W-1:0]      best_index
);

  localparam int                   PAIRS   = POP_SIZE / 2;
  localparam int                   DC_W    = $clog2(FF_LATENCY + 1);
  localparam logic [63:0]          FMIN64  = fitness_min64(FW);
  localparam logic signed [FW-1:0] FIT_MIN = FMIN64[FW-1:0];

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_pair;
  logic [DC_W-1:0]   r_drain;
  logic              w_pair_tc;
  logic              w_start_ok;
  logic [ADDR_W-1:0] w_rd_addr;

  logic              r_vld   [FF_LATENCY+1];
  logic [ADDR_W-1:0] r_vaddr [FF_LATENCY+1];

  logic signed [FW-1:0] w_fit1;
  logic signed [FW-1:0] w_fit2;
  logic signed [FW-1:0] r_best_f;
  logic signed [FW-1:0] w_best_f;
  logic [ADDR_W-1:0]    r_best_i;
  logic [ADDR_W-1:0]    w_best_i;

  assign w_pair_tc  = (r_pair == ADDR_W'(PAIRS - 1));
  assign w_start_ok = (r_state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (w_pair_tc) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain == '0) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The pair counter holds at its last pair rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair  <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        IDLE: r_pair <= '0;
        ISSUE: begin
          if (!w_pair_tc) r_pair <= r_pair + ADDR_W'(1);
          r_drain <= DC_W'(FF_LATENCY);
        end
        DRAIN: begin
          if (r_drain != '0) r_drain <= r_drain - DC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_rd_addr = rd_en ? (r_pair << 1) : '0;
  assign rd_addr   = w_rd_addr;

  // Stage 0 coincides with the RAM data cycle and doubles as the FF enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= FF_LATENCY; i++) begin
        r_vld[i]   <= 1'b0;
        r_vaddr[i] <= '0;
      end
    end else begin
      r_vld[0]   <= rd_en;
      r_vaddr[0] <= w_rd_addr;
      for (int i = 1; i <= FF_LATENCY; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_vaddr[i] <= r_vaddr[i-1];
      end
    end
  end

  fitness_function #(
    .CHROM_WIDTH (CHROM_WIDTH),
    .LATENCY     (FF_LATENCY)
  ) u_ff (
    .clk      (clk),
    .rst      (rst),
    .enable   (r_vld[0]),
    .chrom1   (chrom_rdata1),
    .chrom2   (chrom_rdata2),
    .fitness1 (w_fit1),
    .fitness2 (w_fit2)
  );

  assign fit_wr_en   = r_vld[FF_LATENCY];
  assign fit_wr_addr = r_vaddr[FF_LATENCY];
  assign fit_wdata1  = w_fit1;
  assign fit_wdata2  = w_fit2;

  // Lane 1 (even index) is compared first; strict > keeps the lowest index on ties.
  always_comb begin
    w_best_f = r_best_f;
    w_best_i = r_best_i;
    if (fit_wr_en) begin
      if (w_fit1 > w_best_f) begin
        w_best_f = w_fit1;
        w_best_i = r_vaddr[FF_LATENCY];
      end
      if (w_fit2 > w_best_f) begin
        w_best_f = w_fit2;
        w_best_i = r_vaddr[FF_LATENCY] | ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_f <= FIT_MIN;
      r_best_i <= '0;
    end else if (w_start_ok) begin
      r_best_f <= FIT_MIN;
      r_best_i <= '0;
    end else begin
      r_best_f <= w_best_f;
      r_best_i <= w_best_i;
    end
  end

  assign best_fitness = r_best_f;
  assign best_index   = r_best_i;

endmodule

// File: tb/tb_fitness_scheduler.sv
// Scoreboard bench: two scheduler instances (8 chromosomes/latency 2 and
// 2 chromosomes/latency 1) checked against a cubic fitness reference model.
module tb_fitness_scheduler;

  localparam int CW  = 8;
  localparam int FW  = (CW + 1) * 3;
  localparam int PA  = 8;
  localparam int LA  = 2;
  localparam int AWA = 3;
  localparam int PB  = 2;
  localparam int LB  = 1;
  localparam int AWB = 1;

  typedef struct {
    int     cyc;
    int     addr;
    longint d1;
    longint d2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Instance A
  logic           rst_a, start_a, busy_a, done_a, rd_en_a, wr_en_a;
  logic [AWA-1:0] rd_addr_a, wr_addr_a, best_i_a;
  logic [CW-1:0]  rdata1_a, rdata2_a;
  logic [FW-1:0]  wdata1_a, wdata2_a, best_f_a;
  logic signed [CW-1:0] mem_a [PA];

  // Instance B
  logic           rst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b;
  logic [AWB-1:0] rd_addr_b, wr_addr_b, best_i_b;
  logic [CW-1:0]  rdata1_b, rdata2_b;
  logic [FW-1:0]  wdata1_b, wdata2_b, best_f_b;
  logic signed [CW-1:0] mem_b [PB];

  exp_t qa_rd[$], qa_wr[$], qa_done[$];
  exp_t qb_rd[$], qb_wr[$], qb_done[$];
  int   ba_lo = 1, ba_hi = 0, bb_lo = 1, bb_hi = 0;

  fitness_scheduler #(.CHROM_WIDTH(CW), .POP_SIZE(PA), .FF_LATENCY(LA)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .chrom_rdata1(rdata1_a), .chrom_rdata2(rdata2_a),
    .fit_wr_en(wr_en_a), .fit_wr_addr(wr_addr_a), .fit_wdata1(wdata1_a), .fit_wdata2(wdata2_a),
    .best_fitness(best_f_a), .best_index(best_i_a));

  fitness_scheduler #(.CHROM_WIDTH(CW), .POP_SIZE(PB), .FF_LATENCY(LB)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .chrom_rdata1(rdata1_b), .chrom_rdata2(rdata2_b),
    .fit_wr_en(wr_en_b), .fit_wr_addr(wr_addr_b), .fit_wdata1(wdata1_b), .fit_wdata2(wdata2_b),
    .best_fitness(best_f_b), .best_index(best_i_b));

  // Population RAMs: one-cycle registered read of the pair at rd_addr
  always @(posedge clk) begin
    if (rd_en_a) begin
      rdata1_a <= mem_a[rd_addr_a];
      rdata2_a <= mem_a[rd_addr_a + 1];
    end
    if (rd_en_b) begin
      rdata1_b <= mem_b[rd_addr_b];
      rdata2_b <= mem_b[rd_addr_b + 1];
    end
  end

  function automatic longint ref_fit(input longint x);
    return x * x * x - 15 * x * x + 50 * x;
  endfunction

  function automatic longint fmin();
    return -(longint'(1) << (FW - 1));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected reads, write-backs, done and busy window of one run starting at c0
  task automatic plan(input int which, input int c0);
    int     p, lat, bi;
    longint bf;
    longint v[$];
    exp_t   e;
    if (which == 0) begin
      p = PA / 2; lat = LA;
      foreach (mem_a[i]) v.push_back(longint'(mem_a[i]));
    end else begin
      p = PB / 2; lat = LB;
      foreach (mem_b[i]) v.push_back(longint'(mem_b[i]));
    end
    bf = fmin();
    bi = 0;
    for (int k = 0; k < p; k++) begin
      e = '{c0 + k, 2 * k, 0, 0};
      if (which == 0) qa_rd.push_back(e); else qb_rd.push_back(e);
      e = '{c0 + k + 1 + lat, 2 * k, ref_fit(v[2*k]), ref_fit(v[2*k+1])};
      if (which == 0) qa_wr.push_back(e); else qb_wr.push_back(e);
    end
    for (int i = 0; i < v.size(); i++) begin
      if (ref_fit(v[i]) > bf) begin
        bf = ref_fit(v[i]);
        bi = i;
      end
    end
    e = '{c0 + p + 1 + lat, bi, bf, 0};
    if (which == 0) begin
      qa_done.push_back(e); ba_lo = c0; ba_hi = c0 + p + lat;
    end else begin
      qb_done.push_back(e); bb_lo = c0; bb_hi = c0 + p + lat;
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_a) begin
      if (rd_en_a) begin
        if (qa_rd.size() == 0) chk("a_rd_stray", rd_en_a, 0);
        else begin
          e = qa_rd.pop_front();
          chk("a_rd_cycle", cyc, e.cyc);
          chk("a_rd_addr", rd_addr_a, e.addr);
        end
      end
      if (wr_en_a) begin
        if (qa_wr.size() == 0) chk("a_wr_stray", wr_en_a, 0);
        else begin
          e = qa_wr.pop_front();
          chk("a_wr_cycle", cyc, e.cyc);
          chk("a_wr_addr", wr_addr_a, e.addr);
          chk("a_wdata1", longint'($signed(wdata1_a)), e.d1);
          chk("a_wdata2", longint'($signed(wdata2_a)), e.d2);
        end
      end
      if (done_a) begin
        if (qa_done.size() == 0) chk("a_done_stray", done_a, 0);
        else begin
          e = qa_done.pop_front();
          chk("a_done_cycle", cyc, e.cyc);
          chk("a_best_index", best_i_a, e.addr);
          chk("a_best_fitness", longint'($signed(best_f_a)), e.d1);
        end
      end
      chk("a_busy", busy_a, longint'(cyc >= ba_lo && cyc <= ba_hi));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_b) begin
      if (rd_en_b) begin
        if (qb_rd.size() == 0) chk("b_rd_stray", rd_en_b, 0);
        else begin
          e = qb_rd.pop_front();
          chk("b_rd_cycle", cyc, e.cyc);
          chk("b_rd_addr", rd_addr_b, e.addr);
        end
      end
      if (wr_en_b) begin
        if (qb_wr.size() == 0) chk("b_wr_stray", wr_en_b, 0);
        else begin
          e = qb_wr.pop_front();
          chk("b_wr_cycle", cyc, e.cyc);
          chk("b_wr_addr", wr_addr_b, e.addr);
          chk("b_wdata1", longint'($signed(wdata1_b)), e.d1);
          chk("b_wdata2", longint'($signed(wdata2_b)), e.d2);
        end
      end
      if (done_b) begin
        if (qb_done.size() == 0) chk("b_done_stray", done_b, 0);
        else begin
          e = qb_done.pop_front();
          chk("b_done_cycle", cyc, e.cyc);
          chk("b_best_index", best_i_b, e.addr);
          chk("b_best_fitness", longint'($signed(best_f_b)), e.d1);
        end
      end
      chk("b_busy", busy_b, longint'(cyc >= bb_lo && cyc <= bb_hi));
    end
  end

  task automatic chk_reset_a();
    chk("a_rst_rd_en", rd_en_a, 0);
    chk("a_rst_rd_addr", rd_addr_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_done", done_a, 0);
    chk("a_rst_wr_en", wr_en_a, 0);
    chk("a_rst_wr_addr", wr_addr_a, 0);
    chk("a_rst_wdata1", longint'($signed(wdata1_a)), 0);
    chk("a_rst_wdata2", longint'($signed(wdata2_a)), 0);
    chk("a_rst_best_f", longint'($signed(best_f_a)), fmin());
    chk("a_rst_best_i", best_i_a, 0);
  endtask

  // start high for one cycle; returns at c0 + 1ns
  task automatic go_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    plan(0, cyc + 1);
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic go_b();
    @(posedge clk); #1;
    start_b = 1'b1;
    plan(1, cyc + 1);
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_a();
    int n = 0;
    while ((qa_rd.size() + qa_wr.size() + qa_done.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("a_timeout_pending", qa_rd.size() + qa_wr.size() + qa_done.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while ((qb_rd.size() + qb_wr.size() + qb_done.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("b_timeout_pending", qb_rd.size() + qb_wr.size() + qb_done.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rand_mem_a();
    foreach (mem_a[i]) mem_a[i] = CW'($urandom_range(0, 255));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  initial begin : stim
    logic signed [CW-1:0] v;
    logic signed [CW-1:0] fixed_vec [PA];
    fixed_vec = '{8'sd0, 8'sd1, -8'sd1, 8'sd2, -8'sd2, 8'sd3, -8'sd3, 8'sd5};
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a();
    chk("b_rst_best_f", longint'($signed(best_f_b)), fmin());
    chk("b_rst_busy", busy_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // Directed mixed-sign population: timing, golden values, argmax
    mem_a = fixed_vec;
    go_a();
    wait_a();

    // All chromosomes equal: index 0 must win every tie
    v = CW'($urandom_range(0, 255));
    foreach (mem_a[i]) mem_a[i] = v;
    go_a();
    wait_a();

    // Extremes of the signed range
    foreach (mem_a[i]) mem_a[i] = (i % 2 == 0) ? -8'sd128 : 8'sd127;
    go_a();
    wait_a();

    // Start pulses in c2 and in the done cycle c7 are ignored
    rand_mem_a();
    go_a();
    repeat (2) @(posedge clk);
    #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    wait_a();

    // Asynchronous reset in the middle of c4
    rand_mem_a();
    go_a();
    repeat (4) @(posedge clk);
    #3; rst_a = 1'b1;
    qa_rd.delete(); qa_wr.delete(); qa_done.delete();
    ba_lo = 1; ba_hi = 0;
    #1;
    chk_reset_a();
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0;
    repeat (10) @(posedge clk);
    rand_mem_a();
    go_a();
    wait_a();

    for (int r = 0; r < 6; r++) begin
      rand_mem_a();
      go_a();
      wait_a();
    end

    // Minimum population, then back-to-back start right after done
    foreach (mem_b[i]) mem_b[i] = CW'($urandom_range(0, 255));
    go_b();
    repeat (3) @(posedge clk);
    #1;
    go_b();
    wait_b();

    // Weaker population afterwards: best must be re-initialised, not held
    mem_b[0] = -8'sd100;
    mem_b[1] = -8'sd90;
    go_b();
    wait_b();
    for (int r = 0; r < 4; r++) begin
      foreach (mem_b[i]) mem_b[i] = CW'($urandom_range(0, 255));
      go_b();
      wait_b();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
